vga_timing_gen: RTL

Generates the VGA pixel/line raster counters and the sync and display-enable strobes that drive line_buff_ctrl and the output pixel path. It is the source of pxl_cntr/ln_cntr consumed by the line buffer controller, and of h_sync/v_sync driven to the DAC/connector. Region order on each axis is sync, back porch, display, front porch, with counter value 0 marking the start of sync.

---
 rtl/vga_timing_gen.sv | 129 ++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster generator: pixel/line counters plus registered sync, display-enable and start strobes.
// Optional build macro VGA_TIMING_FRAME_CTR_EN adds a 16-bit frame counter output (frame_cntr_o).
module vga_timing_gen #(
    parameter int WIDTH_PX      = 640,
    parameter int HEIGHT_LNS    = 480,
    parameter int H_SYNC_PX     = 96,
    parameter int H_B_PORCH_PX  = 48,
    parameter int H_F_PORCH_PX  = 16,
    parameter int V_SYNC_LNS    = 2,
    parameter int V_B_PORCH_LNS = 33,
    parameter int V_F_PORCH_LNS = 10,
    parameter int PXL_CTR_WIDTH = 10,
    parameter int LN_CTR_WIDTH  = 10,
    parameter int SYNC_POL      = 0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     en_i,
    output logic [PXL_CTR_WIDTH-1:0] pxl_cntr_o,
    output logic [LN_CTR_WIDTH-1:0]  ln_cntr_o,
    output logic                     h_sync_o,
    output logic                     v_sync_o,
    output logic                     disp_active_o,
    output logic                     line_start_o,
    output logic                     frame_start_o
`ifdef VGA_TIMING_FRAME_CTR_EN
    ,
    output logic [15:0]              frame_cntr_o
`endif
);

    localparam int PXL_MAX = H_SYNC_PX + H_B_PORCH_PX + WIDTH_PX + H_F_PORCH_PX;
    localparam int LN_MAX  = V_SYNC_LNS + V_B_PORCH_LNS + HEIGHT_LNS + V_F_PORCH_LNS;

    localparam logic [PXL_CTR_WIDTH-1:0] PXL_LAST     = PXL_CTR_WIDTH'(PXL_MAX - 1);
    localparam logic [PXL_CTR_WIDTH-1:0] PXL_ONE      = PXL_CTR_WIDTH'(1);
    localparam logic [PXL_CTR_WIDTH-1:0] H_SYNC_END   = PXL_CTR_WIDTH'(H_SYNC_PX);
    localparam logic [PXL_CTR_WIDTH-1:0] H_DISP_BEGIN = PXL_CTR_WIDTH'(H_SYNC_PX + H_B_PORCH_PX);
    localparam logic [PXL_CTR_WIDTH-1:0] H_DISP_END   = PXL_CTR_WIDTH'(H_SYNC_PX + H_B_PORCH_PX + WIDTH_PX);

    localparam logic [LN_CTR_WIDTH-1:0] LN_LAST      = LN_CTR_WIDTH'(LN_MAX - 1);
    localparam logic [LN_CTR_WIDTH-1:0] LN_ONE       = LN_CTR_WIDTH'(1);
    localparam logic [LN_CTR_WIDTH-1:0] V_SYNC_END   = LN_CTR_WIDTH'(V_SYNC_LNS);
    localparam logic [LN_CTR_WIDTH-1:0] V_DISP_BEGIN = LN_CTR_WIDTH'(V_SYNC_LNS + V_B_PORCH_LNS);
    localparam logic [LN_CTR_WIDTH-1:0] V_DISP_END   = LN_CTR_WIDTH'(V_SYNC_LNS + V_B_PORCH_LNS + HEIGHT_LNS);

    localparam logic SYNC_ACT = (SYNC_POL != 0);

    if ((64'd1 << PXL_CTR_WIDTH) < 64'(PXL_MAX)) begin : g_pxl_width_err
        $error("vga_timing_gen: PXL_CTR_WIDTH too small for PXL_MAX");
    end
    if ((64'd1 << LN_CTR_WIDTH) < 64'(LN_MAX)) begin : g_ln_width_err
        $error("vga_timing_gen: LN_CTR_WIDTH too small for LN_MAX");
    end

    logic [PXL_CTR_WIDTH-1:0] pxl_q, pxl_d;
    logic [LN_CTR_WIDTH-1:0]  ln_q, ln_d;
    logic hsync_q, hsync_d;
    logic vsync_q, vsync_d;
    logic disp_q, disp_d;
    logic line_start_q, line_start_d;
    logic frame_start_q, frame_start_d;
`ifdef VGA_TIMING_FRAME_CTR_EN
    logic [15:0] frame_cntr_q, frame_cntr_d;
`endif

    // Strobes are decoded from the next counter values so they land in the same cycle as the counters.
    always_comb begin
        pxl_d = pxl_q;
        ln_d  = ln_q;
        if (en_i) begin
            if (pxl_q == PXL_LAST) begin
                pxl_d = '0;
                ln_d  = (ln_q == LN_LAST) ? '0 : ln_q + LN_ONE;
            end else begin
                pxl_d = pxl_q + PXL_ONE;
            end
        end

        hsync_d       = (pxl_d < H_SYNC_END) ? SYNC_ACT : ~SYNC_ACT;
        vsync_d       = (ln_d < V_SYNC_END) ? SYNC_ACT : ~SYNC_ACT;
        disp_d        = (pxl_d >= H_DISP_BEGIN) && (pxl_d < H_DISP_END) &&
                        (ln_d >= V_DISP_BEGIN) && (ln_d < V_DISP_END);
        line_start_d  = en_i && (pxl_d == '0);
        frame_start_d = line_start_d && (ln_d == '0);
`ifdef VGA_TIMING_FRAME_CTR_EN
        frame_cntr_d = frame_start_d ? frame_cntr_q + 16'd1 : frame_cntr_q;
`endif
    end

    // Reset parks the raster on the last front-porch pixel so the first enabled edge starts a frame.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pxl_q         <= PXL_LAST;
            ln_q          <= LN_LAST;
            hsync_q       <= ~SYNC_ACT;
            vsync_q       <= ~SYNC_ACT;
            disp_q        <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
`ifdef VGA_TIMING_FRAME_CTR_EN
            frame_cntr_q  <= 16'd0;
`endif
        end else begin
            pxl_q         <= pxl_d;
            ln_q          <= ln_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            disp_q        <= disp_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
`ifdef VGA_TIMING_FRAME_CTR_EN
            frame_cntr_q  <= frame_cntr_d;
`endif
        end
    end

    assign pxl_cntr_o    = pxl_q;
    assign ln_cntr_o     = ln_q;
    assign h_sync_o      = hsync_q;
    assign v_sync_o      = vsync_q;
    assign disp_active_o = disp_q;
    assign line_start_o  = line_start_q;
    assign frame_start_o = frame_start_q;
`ifdef VGA_TIMING_FRAME_CTR_EN
    assign frame_cntr_o  = frame_cntr_q;
`endif

endmodule
